keyboard_buffer: RTL and testbench
==================================

# keyboard_buffer

Parametrised successor to the single-key keyboard latch. Sits between the USB HID keycode path and the Apple II soft-switch decode. Detects key presses and typematic repeats from the raw HID keycode/modifier pair, queues the resulting 7-bit characters in a DEPTH-entry FIFO, and presents them one at a time through the $C000 data/strobe latch. The $C010 strobe-clear access is the `read` input.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- FIRST_DELAY, 7000000: cycles from initial press to first repeat (0.5 s at 14 MHz).
- REPEAT_PERIOD, 933333: cycles between subsequent repeats.

Ports:
- Clock_14Mhz  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- read  input  1  single-cycle strobe-clear pulse ($C010 access).
- keycode  input  8  HID usage code; 8'h00 = no key.
- modifier  input  8  HID modifier byte; ctrl = modifier[0] | modifier[4].
- ascii_in  input  8  translated character for the current keycode from the existing translator; 8'h00 = unmapped.
- keyboard_data  output  8  {strobe, char[6:0]}; $C000 read value.
- key_down  output  1  registered (keycode != 8'h00).
- fifo_count  output  $clog2(DEPTH+1)  occupied FIFO entries.
- overflow  output  1  sticky; a character was dropped.

## Operation
- `prev_keycode` is registered every cycle.
- **Press event:** keycode != 0 and keycode != prev_keycode. Direct rollover (A to B) counts as a new press.
- **Repeat timer (32-bit down-counter):**
  - On a press, load FIRST_DELAY.
  - While keycode == prev_keycode != 0 and timer == 1, fire a repeat and reload REPEAT_PERIOD.
  - Otherwise decrement while nonzero.
  - keycode == 0 clears the timer to 0.
- **Character formation:**
  - char = ctrl ? {2'b00, ascii_in[4:0]} : ascii_in[6:0].
  - A press or repeat with ascii_in == 0 enqueues nothing, but still loads the timer.
- **FIFO:**
  - Circular, pointers of width $clog2(DEPTH)+1; full/empty via MSB compare.
  - Push on a press or repeat event.
  - Push while full and no pop in the same cycle: character dropped, overflow <= 1.
  - Push and pop in the same cycle while full: both accepted, count unchanged.
- **Output latch:**
  - When strobe == 0 and FIFO is not empty, pop the head into keyboard_data[6:0] and set strobe = 1.
  - `read` clears strobe. keyboard_data[6:0] keeps the last character (Apple II behaviour).
  - overflow clears on `read`.
  - `read` while strobe == 0: no effect except clearing overflow.
- `read` and a latch load are never in the same cycle: when strobe == 1 no load occurs, and the load after a clear happens on the following cycle.
- **Reset:** keyboard_data = 8'h00, key_down = 0, fifo_count = 0, overflow = 0, pointers = 0, timer = 0, prev_keycode = 8'h00. FIFO contents are don't-care.
- **Reset mid-operation:** all queued characters are discarded. A key still held after deassertion counts as a new press (prev_keycode = 0).

## Timing
- keycode change sampled at edge N: push at edge N+1, fifo_count increments after N+1. Latch loads at edge N+2 if strobe was 0. keyboard_data[7] first reads 1 after edge N+2.
- `read` high at edge M: strobe reads 0 after M. If FIFO not empty, next char and strobe = 1 after edge M+1.
- First repeat push occurs FIRST_DELAY cycles after the press push. Subsequent pushes are every REPEAT_PERIOD cycles while held.
- key_down lags keycode by one cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
Bench parameters: DEPTH=4, FIRST_DELAY=20, REPEAT_PERIOD=5.

- **Single press:** reset, then keycode=8'h04, ascii_in=8'h41 for 3 cycles, then 0. Required: keyboard_data=8'hC1 two edges after the change, fifo_count returns to 0. `read` pulse gives keyboard_data=8'h41.
- **Ctrl:** keycode=8'h06, ascii_in=8'h43, modifier=8'h01. Required: keyboard_data=8'h83.
- **Typematic:** hold keycode 8'h04 for 40 cycles with no `read`. Required: pushes at press+1, +20, +25, +30, +35 (fifo_count 4 after 35 with one latched). Release stops pushes.
- **Overflow:** 6 distinct presses (8'h04..8'h09) with no `read`. Required: latch=8'hC1, fifo_count=4 holding B..E, F dropped, overflow=1. Then 5 `read` pulses two cycles apart yield B,C,D,E in order; overflow clears on the first `read`.
- **Full push/pop in the same cycle:** FIFO full and strobe cleared the cycle before a repeat push. Required: fifo_count stays 4, no overflow.
- **Reset mid-operation:** assert Reset with 3 entries queued and the key held. Required: all outputs 0 immediately (asynchronous). After deassertion the held key enqueues again within 2 cycles.

Source files
------------

// File: rtl/keyboard_buffer.sv
// HID keycode front end for the Apple II keyboard latch: detects presses and
// typematic repeats, queues the characters and presents them through $C000/$C010.
module keyboard_buffer #(
    parameter int DEPTH         = 8,
    parameter int FIRST_DELAY   = 7000000,
    parameter int REPEAT_PERIOD = 933333
) (
    input  logic                         Clock_14Mhz,
    input  logic                         Reset,
    input  logic                         read,
    input  logic [7:0]                   keycode,
    input  logic [7:0]                   modifier,
    input  logic [7:0]                   ascii_in,
    output logic [7:0]                   keyboard_data,
    output logic                         key_down,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Input stage: the keycode/character pair is sampled once, and events are
    // judged from that sample against the one before it.
    logic [7:0]    key_q, prev_q, ascii_q;
    logic          ctrl_q;
    logic [31:0]   timer_q, timer_d;
    logic [PW-1:0] wr_q, rd_q;
    logic [6:0]    data_q;
    logic          strobe_q, overflow_q, key_down_q;
    logic [6:0]    mem [DEPTH];

    logic       press, held, fire, push, pop, empty, full, accept, drop;
    logic [6:0] char_w;

    always_comb begin
        press  = (key_q != 8'h00) && (key_q != prev_q);
        held   = (key_q != 8'h00) && (key_q == prev_q);
        fire   = held && (timer_q == 32'd1);
        push   = (press || fire) && (ascii_q != 8'h00);
        char_w = ctrl_q ? {2'b00, ascii_q[4:0]} : ascii_q[6:0];
        empty  = (wr_q == rd_q);
        full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        // A read never coincides with a latch load; the load follows a cycle later.
        pop    = !strobe_q && !empty && !read;
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    always_comb begin
        timer_d = timer_q;
        if (key_q == 8'h00) begin
            timer_d = 32'd0;
        end else if (press) begin
            timer_d = 32'(FIRST_DELAY);
        end else if (fire) begin
            timer_d = 32'(REPEAT_PERIOD);
        end else if (timer_q != 32'd0) begin
            timer_d = timer_q - 32'd1;
        end
    end

    always_ff @(posedge Clock_14Mhz or posedge Reset) begin
        if (Reset) begin
            key_q      <= 8'h00;
            prev_q     <= 8'h00;
            ascii_q    <= 8'h00;
            ctrl_q     <= 1'b0;
            key_down_q <= 1'b0;
            timer_q    <= 32'd0;
            wr_q       <= '0;
            rd_q       <= '0;
            data_q     <= 7'h00;
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            key_q      <= keycode;
            prev_q     <= key_q;
            ascii_q    <= ascii_in;
            ctrl_q     <= |(modifier & 8'h11);
            key_down_q <= (keycode != 8'h00);
            timer_q    <= timer_d;
            if (accept) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q   <= rd_q + 1'b1;
                data_q <= mem[rd_q[AW-1:0]];
            end
            if (read) begin
                strobe_q <= 1'b0;
            end else if (pop) begin
                strobe_q <= 1'b1;
            end
            // A drop in the same cycle as a read still leaves overflow flagged.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (read) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clock_14Mhz) begin
        if (accept) mem[wr_q[AW-1:0]] <= char_w;
    end

    assign keyboard_data = {strobe_q, data_q};
    assign key_down      = key_down_q;
    assign fifo_count    = CW'(wr_q - rd_q);
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_keyboard_buffer.sv
// Self-checking bench for keyboard_buffer: a vector table, directed multi-cycle
// sequences and random traffic compared against a queue-based reference model.
module tb_keyboard_buffer;

    localparam int DEPTH = 4;
    localparam int FD    = 20;
    localparam int RP    = 5;

    logic       clk = 1'b0;
    logic       Reset;
    logic       read;
    logic [7:0] keycode, modifier, ascii_in;
    logic [7:0] keyboard_data;
    logic       key_down;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keyboard_buffer #(.DEPTH(DEPTH), .FIRST_DELAY(FD), .REPEAT_PERIOD(RP)) dut (
        .Clock_14Mhz  (clk),
        .Reset        (Reset),
        .read         (read),
        .keycode      (keycode),
        .modifier     (modifier),
        .ascii_in     (ascii_in),
        .keyboard_data(keyboard_data),
        .key_down     (key_down),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    // Reference model state: one sample of the key/char pair, the sample
    // before it, cycles held since the press, and a character queue.
    logic [7:0] m_k1, m_k2, m_a1;
    logic       m_c1;
    int         m_age;
    logic [6:0] exp_q[$];
    logic [6:0] m_data;
    logic       m_strobe, m_ovf, m_kdn;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_k1 = 8'h00; m_k2 = 8'h00; m_a1 = 8'h00; m_c1 = 1'b0; m_age = 0;
        exp_q.delete();
        m_data = 7'h00; m_strobe = 1'b0; m_ovf = 1'b0; m_kdn = 1'b0;
    endtask

    task automatic model_step();
        logic press, rep, push, pop, drop;
        logic [6:0] ch;
        press = (m_k1 != 8'h00) && (m_k1 != m_k2);
        rep = 1'b0;
        if (press) begin
            m_age = 0;
        end else if (m_k1 != 8'h00) begin
            m_age++;
            rep = (m_age == FD) || (m_age > FD && ((m_age - FD) % RP) == 0);
        end
        ch   = m_c1 ? {2'b00, m_a1[4:0]} : m_a1[6:0];
        push = (press || rep) && (m_a1 != 8'h00);
        pop  = !m_strobe && (exp_q.size() > 0) && !read;
        drop = 1'b0;
        if (pop) m_data = exp_q.pop_front();
        if (push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ch);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (read) m_ovf = 1'b0;
        if (read) m_strobe = 1'b0;
        else if (pop) m_strobe = 1'b1;
        m_kdn = (keycode != 8'h00);
        m_k2 = m_k1; m_k1 = keycode; m_a1 = ascii_in; m_c1 = modifier[0] | modifier[4];
    endtask

    // Starts and ends at a falling edge: drive, clock, step the model, compare.
    task automatic cyc(input logic [7:0] kc, input logic [7:0] md, input logic [7:0] as,
                       input logic rd);
        keycode = kc; modifier = md; ascii_in = as; read = rd;
        @(posedge clk);
        if (Reset) model_reset();
        else model_step();
        #1;
        chk("model_kbd_data", keyboard_data, {m_strobe, m_data});
        chk("model_key_down", key_down, m_kdn);
        chk("model_fifo_count", fifo_count, exp_q.size());
        chk("model_overflow", overflow, m_ovf);
        @(negedge clk);
    endtask

    // Asserts reset mid-phase so its asynchronous effect is visible before any edge.
    task automatic do_reset();
        #1 Reset = 1'b1;
        #1;
        chk("rst_kbd_data", keyboard_data, 8'h00);
        chk("rst_key_down", key_down, 1'b0);
        chk("rst_fifo_count", fifo_count, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] kc, md, as;
        logic       rd;
        logic [7:0] kd;
        logic       kdn;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [7:0] key_ascii(input logic [7:0] kc);
        case (kc)
            8'h04:   return 8'h41;
            8'h05:   return 8'h42;
            8'h07:   return 8'h7A;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        logic [7:0] cur_kc;
        logic [2:0] exp_cnt;
        Reset = 1'b1; read = 1'b0; keycode = 8'h00; modifier = 8'h00; ascii_in = 8'h00;

        // Single press then ctrl-modified press, one row per clock.
        tbl[0] = '{8'h04, 8'h00, 8'h41, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[1] = '{8'h04, 8'h00, 8'h41, 1'b0, 8'h00, 1'b1, 3'd1};
        tbl[2] = '{8'h04, 8'h00, 8'h41, 1'b0, 8'hC1, 1'b1, 3'd0};
        tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'hC1, 1'b0, 3'd0};
        tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b1, 8'h41, 1'b0, 3'd0};
        tbl[5] = '{8'h06, 8'h01, 8'h43, 1'b0, 8'h41, 1'b1, 3'd0};
        tbl[6] = '{8'h06, 8'h01, 8'h43, 1'b0, 8'h41, 1'b1, 3'd1};
        tbl[7] = '{8'h06, 8'h01, 8'h43, 1'b0, 8'h83, 1'b1, 3'd0};
        tbl[8] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h83, 1'b0, 3'd0};
        tbl[9] = '{8'h00, 8'h00, 8'h00, 1'b1, 8'h03, 1'b0, 3'd0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].kc, tbl[i].md, tbl[i].as, tbl[i].rd);
            chk($sformatf("tbl%0d_kbd_data", i), keyboard_data, tbl[i].kd);
            chk($sformatf("tbl%0d_key_down", i), key_down, tbl[i].kdn);
            chk($sformatf("tbl%0d_fifo_count", i), fifo_count, tbl[i].cnt);
        end

        // Typematic: press push on edge 2, repeats on edges 22/27/32/37/42.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            cyc(8'h04, 8'h00, 8'h41, 1'b0);
            if (i == 2 || i == 21 || i == 22 || i == 27 || i == 32 || i == 36 ||
                i == 37 || i == 40) begin
                case (i)
                    2, 22:   exp_cnt = 3'd1;
                    21:      exp_cnt = 3'd0;
                    27:      exp_cnt = 3'd2;
                    32, 36:  exp_cnt = 3'd3;
                    default: exp_cnt = 3'd4;
                endcase
                chk($sformatf("typ_count_e%0d", i), fifo_count, exp_cnt);
            end
        end
        chk("typ_latched", keyboard_data, 8'hC1);
        // Clear the strobe right before the next repeat: full FIFO pops and pushes together.
        cyc(8'h04, 8'h00, 8'h41, 1'b1);
        chk("full_rd_strobe", keyboard_data, 8'h41);
        cyc(8'h04, 8'h00, 8'h41, 1'b0);
        chk("full_pp_count", fifo_count, 3'd4);
        chk("full_pp_overflow", overflow, 1'b0);
        chk("full_pp_kbd_data", keyboard_data, 8'hC1);
        repeat (10) cyc(8'h00, 8'h00, 8'h00, 1'b0);
        chk("release_count", fifo_count, 3'd4);
        chk("release_overflow", overflow, 1'b0);

        // Overflow: six distinct presses, A latched, B..E queued, F dropped.
        do_reset();
        for (int k = 0; k < 6; k++) cyc(8'h04 + 8'(k), 8'h00, 8'h41 + 8'(k), 1'b0);
        cyc(8'h00, 8'h00, 8'h00, 1'b0);
        chk("ovf_latch", keyboard_data, 8'hC1);
        chk("ovf_count", fifo_count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        for (int r = 0; r < 5; r++) begin
            cyc(8'h00, 8'h00, 8'h00, 1'b1);
            if (r == 0) chk("ovf_clear_on_read", overflow, 1'b0);
            chk($sformatf("ovf_read%0d_data", r), keyboard_data, 8'h41 + 8'(r));
            cyc(8'h00, 8'h00, 8'h00, 1'b0);
            if (r < 4) chk($sformatf("ovf_next%0d", r), keyboard_data, 8'hC2 + 8'(r));
        end
        chk("ovf_drained", fifo_count, 3'd0);
        chk("ovf_last_kept", keyboard_data, 8'h45);

        // Reset mid-operation with three queued and the key still held.
        do_reset();
        for (int i = 1; i <= 33; i++) cyc(8'h04, 8'h00, 8'h41, 1'b0);
        chk("midrst_pre_count", fifo_count, 3'd3);
        do_reset();
        cyc(8'h04, 8'h00, 8'h41, 1'b0);
        cyc(8'h04, 8'h00, 8'h41, 1'b0);
        chk("midrst_repress_count", fifo_count, 3'd1);
        cyc(8'h04, 8'h00, 8'h41, 1'b0);
        chk("midrst_repress_latch", keyboard_data, 8'hC1);

        // Random traffic: sticky keys, rollover, unmapped codes, random ctrl and reads.
        do_reset();
        cur_kc = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(5))
                    0, 1:    cur_kc = 8'h00;
                    2:       cur_kc = 8'h04;
                    3:       cur_kc = 8'h05;
                    4:       cur_kc = 8'h06;
                    default: cur_kc = 8'h07;
                endcase
            end
            cyc(cur_kc, ($urandom_range(3) == 0) ? 8'h10 : 8'h00, key_ascii(cur_kc),
                ($urandom_range(5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
